// File: rtl/truth_table_checker_if.sv
// Handshake bundle carrying (input vector, DUT response) pairs into the checker.
interface truth_table_checker_if #(
  parameter int unsigned N_IN = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_vec;
  logic            in_resp;

  // Vector generator / DUT side drives the pair, checker grants acceptance.
  modport master (output in_valid, output in_vec, output in_resp, input in_ready);
  modport slave  (input in_valid, input in_vec, input in_resp, output in_ready);
endinterface

// File: rtl/truth_table_checker.sv
// Checks a full ascending sweep of DUT responses against an expected truth table.
module truth_table_checker #(
  parameter int unsigned         N_IN      = 4,
  parameter logic [(2**N_IN)-1:0] EXP_TABLE = 16'hAEEE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  truth_table_checker_if.slave  in_if,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [N_IN:0]         err_count_o,
  output logic                  first_fail_seen_o,
  output logic [N_IN-1:0]       first_fail_vec_o,
  output logic                  seq_err_o
);

  localparam int unsigned CW    = N_IN + 1;
  localparam int unsigned N_VEC = 2 ** N_IN;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] exp_idx_q, exp_idx_d;
  logic [CW-1:0]   err_count_q, err_count_d;
  logic            ffs_q, ffs_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic            seq_err_q, seq_err_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            mismatch_c;

  // Next-state, result update and registered-output decode.
  always_comb begin
    state_d     = state_q;
    exp_idx_d   = exp_idx_q;
    err_count_d = err_count_q;
    ffs_d       = ffs_q;
    ffv_d       = ffv_q;
    seq_err_d   = seq_err_q;
    mismatch_c  = (in_if.in_resp != EXP_TABLE[in_if.in_vec]);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          err_count_d = '0;
          ffs_d       = 1'b0;
          ffv_d       = '0;
          seq_err_d   = 1'b0;
          exp_idx_d   = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        // in_ready is high throughout RUN, so in_valid alone marks a transfer.
        if (in_if.in_valid) begin
          if (mismatch_c) begin
            err_count_d = err_count_q + CW'(1);
            if (!ffs_q) begin
              ffs_d = 1'b1;
              ffv_d = in_if.in_vec;
            end
          end
          if (in_if.in_vec != exp_idx_q) begin
            seq_err_d = 1'b1;
          end
          exp_idx_d = exp_idx_q + N_IN'(1);
          if (exp_idx_q == N_IN'(N_VEC - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_RUN);
    busy_d     = (state_d == ST_RUN);
    done_d     = (state_d == ST_DONE);
    pass_d     = (state_d == ST_DONE) && (err_count_d == '0) && !seq_err_d;
  end

  // State and result registers; reset clears everything without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      exp_idx_q   <= '0;
      err_count_q <= '0;
      ffs_q       <= 1'b0;
      ffv_q       <= '0;
      seq_err_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_idx_q   <= exp_idx_d;
      err_count_q <= err_count_d;
      ffs_q       <= ffs_d;
      ffv_q       <= ffv_d;
      seq_err_q   <= seq_err_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign in_if.in_ready    = in_ready_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign err_count_o       = err_count_q;
  assign first_fail_seen_o = ffs_q;
  assign first_fail_vec_o  = ffv_q;
  assign seq_err_o         = seq_err_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker with a queue-based reference model.
module tb_truth_table_checker;

  localparam int unsigned N_IN = 4;
  localparam int unsigned NV   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy, done, pass, ffs, seq_err;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] ffv;

  int checks   = 0;
  int failures = 0;

  logic [N_IN-1:0] q_vec[$];
  logic            q_resp[$];

  always #5 clk = ~clk;

  truth_table_checker_if #(.N_IN(N_IN)) bus ();

  truth_table_checker #(.N_IN(N_IN), .EXP_TABLE(16'hAEEE)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .start_i           (start),
    .in_if             (bus),
    .busy_o            (busy),
    .done_o            (done),
    .pass_o            (pass),
    .err_count_o       (err_count),
    .first_fail_seen_o (ffs),
    .first_fail_vec_o  (ffv),
    .seq_err_o         (seq_err)
  );

  // Reference function of the lab DUT: h = d | (c & ~(a & b)), vector = {a,b,c,d}.
  function automatic logic ref_h(input logic [N_IN-1:0] v);
    return v[0] | (v[1] & ~(v[3] & v[2]));
  endfunction

  function automatic int model_errs();
    int n = 0;
    foreach (q_vec[i]) if (q_resp[i] != ref_h(q_vec[i])) n++;
    return n;
  endfunction

  function automatic logic model_seq();
    foreach (q_vec[i]) if (q_vec[i] != N_IN'(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_ffs();
    return model_errs() != 0;
  endfunction

  function automatic logic [N_IN-1:0] model_ffv();
    foreach (q_vec[i]) if (q_resp[i] != ref_h(q_vec[i])) return q_vec[i];
    return '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, "_err_count"}, 32'(err_count), 32'(model_errs()));
    check({tag, "_ffs"}, 32'(ffs), 32'(model_ffs()));
    check({tag, "_ffv"}, 32'(ffv), 32'(model_ffv()));
    check({tag, "_seq_err"}, 32'(seq_err), 32'(model_seq()));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
    check({tag, "_ffs"}, 32'(ffs), 32'd0);
    check({tag, "_ffv"}, 32'(ffv), 32'd0);
    check({tag, "_seq_err"}, 32'(seq_err), 32'd0);
  endtask

  // One sweep: gap_mode 0 = back-to-back, 1 = alternate cycles, 2 = random gaps.
  // swap_at swaps slots k and k+1; mid_start pulses start with that slot's transfer;
  // stop_after >= 0 abandons the sweep after that many transfers.
  task automatic sweep(input string tag, input int gap_mode, input logic [NV-1:0] flip,
                       input int swap_at, input int mid_start, input int stop_after);
    int              gaps     = 0;
    int              busy_cnt = 0;
    int              ng;
    logic [N_IN-1:0] vec;
    q_vec.delete();
    q_resp.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_start_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_start_done"}, 32'(done), 32'd0);
    check({tag, "_start_pass"}, 32'(pass), 32'd0);
    check_results({tag, "_start"});
    if (busy) busy_cnt++;
    for (int slot = 0; slot < int'(NV); slot++) begin
      if (stop_after >= 0 && slot == stop_after) return;
      ng = (gap_mode == 1) ? ((slot > 0) ? 1 : 0) :
           (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (ng) begin
        bus.in_valid = 1'b0;
        bus.in_vec   = N_IN'($urandom);
        bus.in_resp  = 1'($urandom);
        @(negedge clk);
        if (busy) busy_cnt++;
      end
      gaps += ng;
      vec = N_IN'(slot);
      if (swap_at >= 0 && slot == swap_at)     vec = N_IN'(swap_at + 1);
      if (swap_at >= 0 && slot == swap_at + 1) vec = N_IN'(swap_at);
      bus.in_valid = 1'b1;
      bus.in_vec   = vec;
      bus.in_resp  = ref_h(vec) ^ flip[slot];
      start        = (slot == mid_start);
      @(negedge clk);
      bus.in_valid = 1'b0;
      start        = 1'b0;
      q_vec.push_back(vec);
      q_resp.push_back(ref_h(vec) ^ flip[slot]);
      if (busy) busy_cnt++;
      if (slot < int'(NV) - 1) begin
        check({tag, "_run_err_count"}, 32'(err_count), 32'(model_errs()));
        check({tag, "_run_done"}, 32'(done), 32'd0);
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_ready_end"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'((model_errs() == 0) && !model_seq()));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(int'(NV) + gaps));
    check_results(tag);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_vec   = '0;
    bus.in_resp  = 1'b0;
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(bus.in_ready), 32'd0);

    // Clean back-to-back sweep.
    sweep("clean", 0, 16'h0000, -1, -1, -1);

    // Input in DONE is ignored.
    bus.in_valid = 1'b1;
    bus.in_vec   = 4'd0;
    bus.in_resp  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("done_hold", 32'(done), 32'd1);
    check("done_ignore_err", 32'(err_count), 32'd0);
    check("done_ignore_pass", 32'(pass), 32'd1);

    // Mismatches at vectors 6 and 14 (start from DONE).
    sweep("flip6_14", 0, 16'h4040, -1, -1, -1);
    check("flip6_14_count", 32'(err_count), 32'd2);
    check("flip6_14_vec", 32'(ffv), 32'd6);

    // Alternate-cycle valid: 31 RUN cycles.
    sweep("toggle", 1, 16'h0000, -1, -1, -1);

    // Vectors 3 and 2 swapped in slots 2 and 3.
    sweep("swap", 0, 16'h0000, 2, -1, -1);
    check("swap_seq", 32'(seq_err), 32'd1);

    // Async reset mid-sweep after 7 transfers.
    sweep("partial", 0, 16'h0010, -1, -1, 7);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_rst_idle");
    sweep("after_rst", 0, 16'h0000, -1, -1, -1);

    // start pulsed alongside vector 5 is ignored.
    sweep("mid_start", 0, 16'h0000, -1, 5, -1);

    // Randomized sweeps: sparse mismatches, random gaps, occasional swaps.
    for (int r = 0; r < 6; r++) begin
      logic [NV-1:0] fm;
      int            sw;
      fm = NV'($urandom) & NV'($urandom) & NV'($urandom);
      sw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NV - 2)) : -1;
      sweep("random", 2, fm, sw, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
